mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Round-robin arbiter and sequencer that shares one `mux_2to1` datapath between two requesters. It drives the mux `sel` input and forwards a valid/ready/last handshake between the granted requester and the single downstream consumer. Grants are held for a whole burst, ended by `last` or by a `MAX_BURST` beat limit. The block sits beside the mux: the data buses go through the mux, and only control goes through this block.

## Interface
- `MAX_BURST`, default 4: maximum beats per grant before forced re-arbitration. Legal range is 1 or more.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: requester 0 has a beat on mux input `d0`.
- `req0_last`  in  1: current requester 0 beat ends its burst.
- `req0_ready`  out  1: requester 0 beat accepted this cycle (when `req0_valid` is also high).
- `req1_valid`, `req1_last`  in  1 each: same as requester 0, for mux input `d1`.
- `req1_ready`  out  1: same as `req0_ready`, for requester 1.
- `sel`  out  2: mux select, registered. `2'b00` selects d0, `2'b01` selects d1, `2'b10` is idle and makes the mux output zero.
- `gnt`  out  2: one-hot grant, registered. Bit 0 is requester 0, bit 1 is requester 1. Value is `2'b00` when idle.
- `out_valid`  out  1: downstream beat valid.
- `out_last`  out  1: downstream beat is the last beat of its burst.
- `out_ready`  in  1: downstream accepts the beat.

## Operation
- **FSM states:** IDLE, G0, G1. State is encoded into the registered `sel`/`gnt` outputs:
  - IDLE: `sel`=10, `gnt`=00.
  - G0: `sel`=00, `gnt`=01.
  - G1: `sel`=01, `gnt`=10.
- **Priority pointer `ptr`:** 1 bit. It names the requester preferred on a tie and is set to the requester *not* most recently served. Reset value 0.
- **Beat counter `cnt`:** width `$clog2(MAX_BURST)+1`. It is cleared on every grant change and increments on each accepted beat.
- **IDLE:**
  - Only `req0_valid` high: go to G0.
  - Only `req1_valid` high: go to G1.
  - Both high: go to G0 if `ptr`=0, else G1.
  - Neither high: stay in IDLE.
- **Gx, combinational outputs:**
  - `out_valid` = `reqx_valid`.
  - `out_last` = `reqx_last`.
  - `reqx_ready` = `out_ready`.
  - The other requester's ready is 0.
- **Gx, beat acceptance:** a beat is accepted when `reqx_valid && out_ready`.
- **Burst end:** an accepted beat with `reqx_last`=1, or the accepted beat that makes `cnt`=`MAX_BURST`.
- **At burst end:**
  - `ptr` is set to the other requester.
  - Next state is G(other) if the other requester's valid is high in that cycle, else IDLE.
  - The served requester never re-grants back-to-back. It waits through one IDLE cycle first.
- **Gx with no burst end:** stay in Gx, including while `reqx_valid`=0. The granted requester owns the path until its burst ends.
- **IDLE, combinational outputs:** `out_valid`=0, `out_last`=0, both readies 0.
- **Requester rule:** once `reqx_valid` is high, the requester holds valid, last and data stable until ready. The bench checks this; the RTL does not.
- **`MAX_BURST`=1:** every accepted beat ends the burst.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low): state IDLE, `sel`=10, `gnt`=00, `ptr`=0, `cnt`=0, `out_valid`=0, `out_last`=0, `req0_ready`=0, `req1_ready`=0.
- **Reset mid-burst:** the burst is aborted with no further handshakes. After release, arbitration restarts from IDLE with `ptr`=0.
- **Grant latency:** request seen in IDLE at edge t gives `sel`/`gnt` valid after edge t+1. The first beat can be accepted in the cycle after t+1.
- **Handoff latency:** the handoff G0 to G1 (or G1 to G0) has zero bubble. The first beat of the new owner can transfer in the cycle after the old owner's final beat.
- **Mux timing:** `sel` is registered, so the mux output is stable for the full cycle in which `out_valid` is asserted.
- **Backpressure:** `out_ready`=0 holds state, `cnt` and `sel`. No beat is lost or duplicated.
- **Same-cycle request and burst end:** a request arriving in the same cycle as a burst end is honoured by the end-of-burst decision, with no extra IDLE cycle.

## Test plan
- **Reset:** hold `rst_n`=0 with both valids=1 -> `sel`=10, `gnt`=00, `out_valid`=0, both readies 0. Release -> G0 one cycle later, because `ptr`=0.
- **Single burst:** `req0_valid`=1 for 3 beats, last on beat 3, `out_ready`=1 -> `sel`=00 from cycle 1; beats accepted in cycles 1–3 with `out_last` only in cycle 3; `sel`=10 in cycle 4.
- **Tie and handoff:** both valid from IDLE with `ptr`=0 -> G0 first. Req0 2-beat burst -> G1 (`sel`=01) in the cycle right after req0's last beat, with no IDLE. After req1's burst, `ptr`=0.
- **Backpressure:** in G1, `out_ready`=0 for 2 cycles mid-burst -> `req1_ready`=0, `sel` stays 01, `cnt` unchanged, and the burst completes with exactly the sent beat count.
- **Burst limit:** `MAX_BURST`=4, req0 streams 8 beats without last, `req1_valid`=1 waiting -> switch to G1 after beat 4. Req0 is re-granted only after req1's burst ends.
- **Reset mid-burst:** assert `rst_n`=0 during G1 beat 2 -> outputs return to reset values immediately, without waiting for a clock edge. After release with only `req1_valid`=1 -> G1 granted afresh with `cnt`=0.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that owns the select of a shared 2:1 mux and forwards the
// valid/ready/last handshake between the granted requester and one consumer.
module mux2_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] sel,
  output logic [1:0] gnt,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  // State encoding doubles as the mux select, so sel comes straight off the flops.
  typedef enum logic [1:0] {
    G0   = 2'b00,
    G1   = 2'b01,
    IDLE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic own1_s;
  logic cur_valid_s;
  logic cur_last_s;
  logic oth_valid_s;
  logic accept_s;
  logic burst_end_s;

  assign own1_s      = (state_q == G1);
  assign cur_valid_s = own1_s ? req1_valid : req0_valid;
  assign cur_last_s  = own1_s ? req1_last  : req0_last;
  assign oth_valid_s = own1_s ? req0_valid : req1_valid;
  assign accept_s    = (state_q != IDLE) && cur_valid_s && out_ready;
  assign burst_end_s = cur_last_s || ((cnt_q + CW'(1)) == MAX_C);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0_valid && (!req1_valid || !ptr_q)) begin
          state_d = G0;
        end else if (req1_valid) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G0, G1: begin
        if (accept_s && burst_end_s) begin
          // Served requester drops to IDLE if the other side has nothing waiting.
          ptr_d   = ~own1_s;
          cnt_d   = '0;
          state_d = oth_valid_s ? (own1_s ? G0 : G1) : IDLE;
        end else if (accept_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    case (state_d)
      G0:      gnt_d = 2'b01;
      G1:      gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake is steered combinationally from the registered grant.
  always_comb begin
    out_valid  = 1'b0;
    out_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      G0: begin
        out_valid  = req0_valid;
        out_last   = req0_last;
        req0_ready = out_ready;
      end
      G1: begin
        out_valid  = req1_valid;
        out_last   = req1_last;
        req1_ready = out_ready;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign sel = state_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: requester drivers feed per-port beat queues,
// a monitor checks every downstream beat against hand-ordered expectations.
module tb_mux2_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] tag;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic       last;
    logic [7:0] tag;
  } drv_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [1:0] sel, gnt;
  logic       out_valid, out_last;
  logic       out_ready = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, mux_out;

  int tests_run = 0;
  int tests_failed = 0;

  beat_t sb[$];
  drv_t  q0[$];
  drv_t  q1[$];

  mux2_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .sel(sel), .gnt(gnt),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared datapath mux.
  always_comb begin
    if (sel == 2'b00)      mux_out = d0;
    else if (sel == 2'b01) mux_out = d1;
    else                   mux_out = 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push0(input logic l, input logic [7:0] t);
    q0.push_back({l, t});
  endtask

  task automatic push1(input logic l, input logic [7:0] t);
    q1.push_back({l, t});
  endtask

  task automatic expect_beat(input logic [1:0] s, input logic [7:0] t, input logic l);
    sb.push_back({s, t, l});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin : drv0
    logic acc;
    forever begin
      @(negedge clk);
      acc = req0_valid && req0_ready;
      @(posedge clk);
      #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1'b1;
        {req0_last, d0} = q0[0];
      end else begin
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        d0         = 8'h00;
      end
    end
  end

  initial begin : drv1
    logic acc;
    forever begin
      @(negedge clk);
      acc = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_last, d1} = q1[0];
      end else begin
        req1_valid = 1'b0;
        req1_last  = 1'b0;
        d1         = 8'h00;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and watches requester stability.
  initial begin : mon
    beat_t      e;
    logic       p0, p1;
    logic [8:0] h0, h1;
    p0 = 1'b0;
    p1 = 1'b0;
    h0 = 9'h000;
    h1 = 9'h000;
    forever begin
      @(negedge clk);
      if (p0) begin
        tests_run++;
        if (!req0_valid || {req0_last, d0} != h0) begin
          tests_failed++;
          $display("FAIL hold0: got v=%b %h expected v=1 %h", req0_valid, {req0_last, d0}, h0);
        end
      end
      if (p1) begin
        tests_run++;
        if (!req1_valid || {req1_last, d1} != h1) begin
          tests_failed++;
          $display("FAIL hold1: got v=%b %h expected v=1 %h", req1_valid, {req1_last, d1}, h1);
        end
      end
      p0 = req0_valid && !req0_ready;
      h0 = {req0_last, d0};
      p1 = req1_valid && !req1_ready;
      h1 = {req1_last, d1};
      if (rst_n && out_valid && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL beat: got unexpected sel=%b data=%h last=%b expected none", sel, mux_out, out_last);
        end else begin
          e = sb.pop_front();
          if (e != {sel, mux_out, out_last}) begin
            tests_failed++;
            $display("FAIL beat: got sel=%b data=%h last=%b expected sel=%b data=%h last=%b",
                     sel, mux_out, out_last, e.sel, e.tag, e.last);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset with both requesters valid, then tie from IDLE and zero-bubble handoff.
    out_ready = 1'b1;
    push0(1'b0, 8'hA1); push0(1'b1, 8'hA2);
    push1(1'b0, 8'hB1); push1(1'b1, 8'hB2);
    expect_beat(2'b00, 8'hA1, 1'b0); expect_beat(2'b00, 8'hA2, 1'b1);
    expect_beat(2'b01, 8'hB1, 1'b0); expect_beat(2'b01, 8'hB2, 1'b1);
    repeat (3) step();
    check("rst_valids", {req0_valid, req1_valid}, 2'b11);
    check("rst_sel", sel, 2'b10);
    check("rst_gnt", gnt, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_readies", {req0_ready, req1_ready}, 2'b00);
    rst_n = 1'b1;
    step();
    check("tie_sel", sel, 2'b00);
    check("tie_gnt", gnt, 2'b01);
    step();
    check("tie_cnt", dut.cnt_q, 1);
    step();
    check("handoff_sel", sel, 2'b01);
    check("handoff_gnt", gnt, 2'b10);
    check("handoff_cnt", dut.cnt_q, 0);
    check("handoff_ptr", dut.ptr_q, 1'b1);
    drain(20);
    step();
    check("a_idle_sel", sel, 2'b10);
    check("a_ptr", dut.ptr_q, 1'b0);

    // Single 3-beat burst on requester 0.
    push0(1'b0, 8'hC1); push0(1'b0, 8'hC2); push0(1'b1, 8'hC3);
    expect_beat(2'b00, 8'hC1, 1'b0); expect_beat(2'b00, 8'hC2, 1'b0); expect_beat(2'b00, 8'hC3, 1'b1);
    step();
    check("b_latency_gnt", gnt, 2'b00);
    step();
    check("b_sel", sel, 2'b00);
    step();
    step();
    check("b_beats", sb.size(), 0);
    step();
    check("b_idle_sel", sel, 2'b10);

    // Backpressure in G1 for two cycles mid-burst.
    push1(1'b0, 8'hD1); push1(1'b0, 8'hD2); push1(1'b1, 8'hD3);
    expect_beat(2'b01, 8'hD1, 1'b0); expect_beat(2'b01, 8'hD2, 1'b0); expect_beat(2'b01, 8'hD3, 1'b1);
    step();
    check("c_latency_gnt", gnt, 2'b00);
    step();
    check("c_sel", sel, 2'b01);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("c_bp_ready", req1_ready, 1'b0);
      check("c_bp_sel", sel, 2'b01);
      check("c_bp_cnt", dut.cnt_q, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(20);
    step();
    check("c_idle_sel", sel, 2'b10);
    check("c_ptr", dut.ptr_q, 1'b0);

    // Burst limit: req0 streams 8 beats without last while req1 waits.
    for (int i = 1; i <= 8; i++) push0(1'b0, 8'hE0 + 8'(i));
    push1(1'b0, 8'hF1); push1(1'b1, 8'hF2);
    for (int i = 1; i <= 4; i++) expect_beat(2'b00, 8'hE0 + 8'(i), 1'b0);
    expect_beat(2'b01, 8'hF1, 1'b0); expect_beat(2'b01, 8'hF2, 1'b1);
    for (int i = 5; i <= 8; i++) expect_beat(2'b00, 8'hE0 + 8'(i), 1'b0);
    step();
    step();
    check("d_gnt0", gnt, 2'b01);
    repeat (3) step();
    check("d_cnt_before_limit", dut.cnt_q, 3);
    step();
    check("d_limit_gnt1", gnt, 2'b10);
    step();
    step();
    check("d_regrant_gnt0", gnt, 2'b01);
    drain(20);
    step();
    check("d_idle_sel", sel, 2'b10);
    check("d_ptr", dut.ptr_q, 1'b1);

    // Reset during G1 beat 2, then fresh grant with only requester 1 valid.
    push1(1'b0, 8'h91); push1(1'b0, 8'h92); push1(1'b1, 8'h93);
    expect_beat(2'b01, 8'h91, 1'b0);
    step();
    check("e_latency_gnt", gnt, 2'b00);
    step();
    check("e_gnt1", gnt, 2'b10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("e_async_sel", sel, 2'b10);
    check("e_async_gnt", gnt, 2'b00);
    check("e_async_valid", out_valid, 1'b0);
    check("e_async_ready", req1_ready, 1'b0);
    check("e_async_cnt", dut.cnt_q, 0);
    check("e_beats_before_rst", sb.size(), 0);
    expect_beat(2'b01, 8'h92, 1'b0); expect_beat(2'b01, 8'h93, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    check("e_regrant_gnt", gnt, 2'b10);
    check("e_regrant_cnt", dut.cnt_q, 0);
    check("e_regrant_ptr", dut.ptr_q, 1'b0);
    drain(20);
    step();
    check("e_idle_sel", sel, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
